// File: rtl/kronos_bus_arb.sv
// Two-requester memory-port arbiter for the Kronos core: instruction fetch vs. load/store.
// Registers the winner onto the port, steers ack/data back, and aborts stalled transactions.
module kronos_bus_arb #(
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_ack,
  output logic [31:0] instr_data,
  output logic        instr_err,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic        data_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ack
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;

  state_t        state, state_nxt;
  logic          last_d;   // 1 = data owned the most recent grant
  logic [CW-1:0] cnt;
  logic          pick_d, pick_i, tmo;

  always_comb begin
    pick_d = 1'b0;
    if (ROUND_ROBIN == 0) pick_d = data_req;
    else                  pick_d = data_req & (~instr_req | ~last_d);
    pick_i = instr_req & ~pick_d;
    // an ack in the final cycle beats the timeout
    tmo = (TIMEOUT > 0) && (state != IDLE) && (cnt == CNT_LAST) && !mem_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pick_d)         state_nxt = DBUS;
                 else if (pick_i)    state_nxt = IBUS;
      IBUS, DBUS: if (mem_ack || tmo) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_mask    <= '0;
      mem_wr_en   <= 1'b0;
      mem_req     <= 1'b0;
      last_d      <= 1'b0;
      cnt         <= '0;
    end else if (state == IDLE) begin
      if (pick_d) begin
        mem_addr    <= data_addr;
        mem_wr_data <= data_wr_data;
        mem_mask    <= data_mask;
        mem_wr_en   <= data_wr_en;
        mem_req     <= 1'b1;
        last_d      <= 1'b1;
        cnt         <= '0;
      end else if (pick_i) begin
        mem_addr    <= instr_addr;
        mem_mask    <= 4'hF;
        mem_wr_en   <= 1'b0;
        mem_req     <= 1'b1;
        last_d      <= 1'b0;
        cnt         <= '0;
      end
    end else begin
      if (mem_ack || tmo)  mem_req <= 1'b0;
      else if (cnt != '1)  cnt     <= cnt + CW'(1);
    end
  end

  always_comb begin
    instr_ack    = mem_ack & (state == IBUS);
    data_ack     = mem_ack & (state == DBUS);
    instr_err    = tmo & (state == IBUS);
    data_err     = tmo & (state == DBUS);
    instr_data   = mem_rd_data;
    data_rd_data = mem_rd_data;
  end

endmodule

// File: tb/tb_kronos_bus_arb.sv
// Directed bench: u0 = fixed priority with TIMEOUT=4, u1 = round robin with default timeout.
// Both share stimulus; each phase checks the instance it targets.
module tb_kronos_bus_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] instr_addr, data_addr, data_wr_data, mem_rd_data;
  logic [3:0]  data_mask;
  logic        instr_req, data_req, data_wr_en, mem_ack;

  logic        i0_ack, i0_err, d0_ack, d0_err, m0_req, m0_we;
  logic [31:0] i0_data, d0_data, m0_addr, m0_wd;
  logic [3:0]  m0_mask;
  logic        i1_ack, i1_err, d1_ack, d1_err, m1_req, m1_we;
  logic [31:0] i1_data, d1_data, m1_addr, m1_wd;
  logic [3:0]  m1_mask;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  kronos_bus_arb #(.ROUND_ROBIN(0), .TIMEOUT(4)) u0 (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(i0_ack),
    .instr_data(i0_data), .instr_err(i0_err),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
    .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(d0_ack),
    .data_rd_data(d0_data), .data_err(d0_err),
    .mem_addr(m0_addr), .mem_wr_data(m0_wd), .mem_mask(m0_mask), .mem_wr_en(m0_we),
    .mem_req(m0_req), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack));

  kronos_bus_arb #(.ROUND_ROBIN(1)) u1 (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(i1_ack),
    .instr_data(i1_data), .instr_err(i1_err),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
    .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(d1_ack),
    .data_rd_data(d1_data), .data_err(d1_err),
    .mem_addr(m1_addr), .mem_wr_data(m1_wd), .mem_mask(m1_mask), .mem_wr_en(m1_we),
    .mem_req(m1_req), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_req = 0; data_req = 0; mem_ack = 0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    instr_addr = 0; data_addr = 0; data_wr_data = 0; data_mask = 0;
    data_wr_en = 0; instr_req = 0; data_req = 0; mem_ack = 0; mem_rd_data = 0;
    #3;
    chk("rst_mem_req", m0_req, 0);
    chk("rst_mem_addr", m0_addr, 0);
    chk("rst_mem_mask", m0_mask, 0);
    chk("rst_mem_wr_en", m0_we, 0);
    chk("rst_mem_wd", m0_wd, 0);
    chk("rst_acks", {i0_ack, d0_ack, i0_err, d0_err}, 0);
    cyc(); cyc();
    rst = 1'b0;

    // single fetch, memory acks in the first cycle
    instr_req = 1; instr_addr = 32'h100; #2;
    chk("sf_idle_ack", i0_ack, 0);
    cyc();
    mem_ack = 1; mem_rd_data = 32'hDEADBEEF; #2;
    chk("sf_req", m0_req, 1);
    chk("sf_addr", m0_addr, 32'h100);
    chk("sf_mask", m0_mask, 4'hF);
    chk("sf_we", m0_we, 0);
    chk("sf_iack", i0_ack, 1);
    chk("sf_idata", i0_data, 32'hDEADBEEF);
    chk("sf_dack", d0_ack, 0);
    instr_req = 0;
    cyc(); mem_ack = 0; #2;
    chk("sf_release", m0_req, 0);
    chk("sf_iack_once", i0_ack, 0);
    cyc();
    chk("sf_req_once", m0_req, 0);

    // both pending, fixed priority: data three times, then instruction
    do_reset();
    instr_req = 1; instr_addr = 32'h300;
    data_req = 1; data_addr = 32'h200; data_wr_en = 1; data_mask = 4'h3; data_wr_data = 32'h1234;
    for (int t = 0; t < 3; t++) begin
      cyc();
      chk("fp_d_addr", m0_addr, 32'h200);
      chk("fp_d_mask", m0_mask, 4'h3);
      chk("fp_d_we", m0_we, 1);
      chk("fp_d_wd", m0_wd, 32'h1234);
      mem_ack = 1; #2;
      chk("fp_dack", d0_ack, 1);
      chk("fp_iack", i0_ack, 0);
      if (t == 2) data_req = 0;
      cyc(); mem_ack = 0; #2;
      chk("fp_gap", m0_req, 0);
    end
    cyc();
    chk("fp_i_req", m0_req, 1);
    chk("fp_i_addr", m0_addr, 32'h300);
    chk("fp_i_we", m0_we, 0);
    chk("fp_i_mask", m0_mask, 4'hF);
    chk("fp_i_wd_hold", m0_wd, 32'h1234);
    mem_ack = 1; #2;
    chk("fp_i_ack", i0_ack, 1);
    instr_req = 0;
    cyc(); mem_ack = 0;

    // both pending, round robin: D, I, D, I with one idle cycle between
    do_reset();
    instr_req = 1; instr_addr = 32'h300;
    data_req = 1; data_addr = 32'h200; data_wr_en = 1; data_mask = 4'h3;
    for (int t = 0; t < 4; t++) begin
      cyc();
      chk("rr_req", m1_req, 1);
      chk("rr_addr", m1_addr, (t % 2 == 0) ? 32'h200 : 32'h300);
      mem_ack = 1; #2;
      chk("rr_dack", d1_ack, (t % 2 == 0) ? 1 : 0);
      chk("rr_iack", i1_ack, (t % 2 == 0) ? 0 : 1);
      if (t == 3) begin instr_req = 0; data_req = 0; end
      cyc(); mem_ack = 0; #2;
      chk("rr_gap", m1_req, 0);
    end

    // wait states: ack in grant cycle 5, port fields held throughout
    do_reset();
    data_req = 1; data_addr = 32'h400; data_wr_data = 32'hA5A5A5A5;
    data_mask = 4'hC; data_wr_en = 1;
    cyc();
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin mem_ack = 1; mem_rd_data = 32'h0BADF00D; end
      #2;
      chk("ws_req", m1_req, 1);
      chk("ws_addr", m1_addr, 32'h400);
      chk("ws_wd", m1_wd, 32'hA5A5A5A5);
      chk("ws_mask", m1_mask, 4'hC);
      chk("ws_we", m1_we, 1);
      chk("ws_err", d1_err, 0);
      chk("ws_ack", d1_ack, (c == 5) ? 1 : 0);
      if (c == 5) data_req = 0;
      cyc();
    end
    mem_ack = 0; #2;
    chk("ws_release", m1_req, 0);

    // timeout: no ack -> data_err in grant cycle 4
    do_reset();
    data_req = 1; data_addr = 32'h500; data_wr_en = 0; data_mask = 4'hF;
    cyc();
    for (int c = 1; c <= 3; c++) begin
      #2;
      chk("to_req", m0_req, 1);
      chk("to_noerr", d0_err, 0);
      cyc();
    end
    #2;
    chk("to_err", d0_err, 1);
    chk("to_noack", d0_ack, 0);
    chk("to_ierr", i0_err, 0);
    data_req = 0;
    cyc(); #2;
    chk("to_drop", m0_req, 0);
    chk("to_err_pulse", d0_err, 0);

    // ack in grant cycle 4 wins over the timeout
    data_req = 1;
    cyc();
    for (int c = 1; c <= 3; c++) cyc();
    mem_ack = 1; #2;
    chk("ta_ack", d0_ack, 1);
    chk("ta_noerr", d0_err, 0);
    data_req = 0;
    cyc(); mem_ack = 0; #2;
    chk("ta_release", m0_req, 0);

    // async reset during DBUS, pending fetch granted on the first edge after release
    do_reset();
    data_req = 1; data_addr = 32'h600;
    cyc();
    chk("ar_dbus", m0_req, 1);
    instr_req = 1; instr_addr = 32'h700;
    #2; rst = 1'b1; data_req = 0; #1;
    chk("ar_req_drop", m0_req, 0);
    chk("ar_addr_clr", m0_addr, 0);
    rst = 1'b0;
    cyc();
    chk("ar_grant", m0_req, 1);
    chk("ar_iaddr", m0_addr, 32'h700);
    chk("ar_no_stale", {i0_ack, d0_ack, i0_err, d0_err}, 0);
    mem_ack = 1; #2;
    chk("ar_iack", i0_ack, 1);
    instr_req = 0;
    cyc(); mem_ack = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
